pe_d_gen: RTL and testbench

PE_D_GEN -- requirements
Module: pe_d_gen

---
 rtl/pe_pkg.sv | 16 +
 rtl/pe_round_sat.sv | 33 +++
 rtl/pe_d_gen.sv | 140 ++++++++++++++
 tb/tb_pe_d_gen.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the processing-element datapath: default widths and
// the controller state encoding.
package pe_pkg;

  localparam int unsigned PeDw   = 16;
  localparam int unsigned PeAw   = 40;
  localparam int unsigned PeFrac = 8;
  localparam int unsigned PeKw   = 10;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDone  = 2'd2
  } pe_state_e;

endpackage

// File: rtl/pe_round_sat.sv
// Rounds a signed accumulator to nearest by dropping FRAC fraction bits, then
// saturates the result to a DW-bit signed value.
module pe_round_sat import pe_pkg::*; #(
  parameter int unsigned AW   = PeAw,
  parameter int unsigned DW   = PeDw,
  parameter int unsigned FRAC = PeFrac
) (
  input  logic signed [AW-1:0] acc_i,
  output logic signed [DW-1:0] res_o
);

  localparam int unsigned       RndSh  = (FRAC > 0) ? FRAC - 1 : 0;
  localparam logic signed [AW:0] RndAdd = (FRAC > 0) ? ((AW + 1)'(1) << RndSh) : '0;

  logic signed [AW:0] rnd;
  logic signed [AW:0] shf;
  logic               fits;

  always_comb begin
    // One guard bit keeps the rounding add from overflowing.
    rnd  = $signed({acc_i[AW-1], acc_i}) + RndAdd;
    shf  = rnd >>> FRAC;
    fits = (&shf[AW:DW-1]) | (~|shf[AW:DW-1]);
    if (fits) begin
      res_o = shf[DW-1:0];
    end else if (shf[AW]) begin
      res_o = {1'b1, {(DW-1){1'b0}}};
    end else begin
      res_o = {1'b0, {(DW-1){1'b1}}};
    end
  end

endmodule

// File: rtl/pe_d_gen.sv
// Systolic processing element: forwards weight/ifmap, accumulates k_len MACs
// with saturation and injects its rounded result into the output chain.
module pe_d_gen import pe_pkg::*; #(
  parameter int unsigned DW   = PeDw,
  parameter int unsigned AW   = PeAw,
  parameter int unsigned FRAC = PeFrac,
  parameter int unsigned KW   = PeKw
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_in,
  input  logic                 en_psum,
  input  logic                 start,
  input  logic [KW-1:0]        k_len,
  input  logic signed [DW-1:0] weight_in,
  input  logic signed [DW-1:0] ifmap_in_nbr,
  input  logic signed [DW-1:0] ifmap_in_bram,
  input  logic                 ifmap_sel_ctrl,
  input  logic signed [DW-1:0] output_in,
  input  logic                 output_in_valid,
  input  logic                 output_eject_ctrl,
  output logic signed [DW-1:0] weight_out,
  output logic signed [DW-1:0] ifmap_out,
  output logic signed [DW-1:0] output_out,
  output logic                 output_out_valid,
  output logic                 busy,
  output logic                 done
);

  pe_state_e            state_q, state_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [KW-1:0]        cnt_q, cnt_d;
  logic signed [DW-1:0] weight_q, weight_d;
  logic signed [DW-1:0] ifmap_q, ifmap_d;
  logic signed [DW-1:0] out_q, out_d;
  logic                 out_valid_q, out_valid_d;

  logic signed [DW-1:0]   ifmap_sel;
  logic signed [DW-1:0]   result;
  logic signed [2*DW-1:0] prod;
  logic signed [AW:0]     sum;
  logic                   mac;

  assign ifmap_sel = ifmap_sel_ctrl ? ifmap_in_bram : ifmap_in_nbr;
  assign prod      = weight_in * ifmap_sel;
  assign sum       = $signed({acc_q[AW-1], acc_q}) + (AW + 1)'(prod);
  assign mac       = en_in & en_psum;

  pe_round_sat #(
    .AW   (AW),
    .DW   (DW),
    .FRAC (FRAC)
  ) u_round_sat (
    .acc_i (acc_q),
    .res_o (result)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    weight_d    = weight_q;
    ifmap_d     = ifmap_q;
    out_d       = out_q;
    out_valid_d = 1'b0;

    if (en_in) begin
      weight_d = weight_in;
      ifmap_d  = ifmap_sel;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d   = '0;
          cnt_d   = k_len;
          state_d = (k_len == '0) ? StDone : StAccum;
        end
      end
      StAccum: begin
        if (mac) begin
          // Guard bit disagreeing with the sign bit means the AW-bit sum overflowed.
          if (sum[AW] != sum[AW-1]) begin
            acc_d = sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
          end else begin
            acc_d = sum[AW-1:0];
          end
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == KW'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (output_eject_ctrl) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (output_eject_ctrl) begin
      if (state_q == StDone) begin
        out_d       = result;
        out_valid_d = 1'b1;
      end else begin
        out_d       = output_in;
        out_valid_d = output_in_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      cnt_q       <= '0;
      weight_q    <= '0;
      ifmap_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      weight_q    <= weight_d;
      ifmap_q     <= ifmap_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign weight_out       = weight_q;
  assign ifmap_out        = ifmap_q;
  assign output_out       = out_q;
  assign output_out_valid = out_valid_q;
  assign busy             = (state_q == StAccum);
  assign done             = (state_q == StDone);

endmodule

// File: tb/tb_pe_d_gen.sv
// Scoreboard bench for pe_d_gen: expected chain outputs are queued when driven
// and checked when output_out_valid appears.
module tb_pe_d_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en_in = 1'b0, en_psum = 1'b0, start = 1'b0;
  logic [9:0]  k_len = '0;
  logic [15:0] weight_in = '0, ifmap_in_nbr = '0, ifmap_in_bram = '0, output_in = '0;
  logic        ifmap_sel_ctrl = 1'b0, output_in_valid = 1'b0, output_eject_ctrl = 1'b0;
  logic [15:0] weight_out, ifmap_out, output_out;
  logic        output_out_valid, busy, done;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  pe_d_gen dut (
    .clk               (clk),
    .rst               (rst),
    .en_in             (en_in),
    .en_psum           (en_psum),
    .start             (start),
    .k_len             (k_len),
    .weight_in         (weight_in),
    .ifmap_in_nbr      (ifmap_in_nbr),
    .ifmap_in_bram     (ifmap_in_bram),
    .ifmap_sel_ctrl    (ifmap_sel_ctrl),
    .output_in         (output_in),
    .output_in_valid   (output_in_valid),
    .output_eject_ctrl (output_eject_ctrl),
    .weight_out        (weight_out),
    .ifmap_out         (ifmap_out),
    .output_out        (output_out),
    .output_out_valid  (output_out_valid),
    .busy              (busy),
    .done              (done)
  );

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic longint sat40(input longint a);
    longint mx, mn;
    mx = (longint'(1) <<< 39) - 1;
    mn = -(longint'(1) <<< 39);
    if (a > mx) return mx;
    if (a < mn) return mn;
    return a;
  endfunction

  function automatic logic [15:0] model_res(input longint acc);
    longint s;
    s = (acc + 128) >>> 8;
    if (s > 32767) return 16'h7fff;
    if (s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  // Scoreboard consumer
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (output_out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("chain_data", output_out, e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input int k, input logic [15:0] w0, input logic [15:0] f0,
                         input bit rnd, input bit sel, input bit gaps);
    longint acc;
    logic [15:0] w, f;
    acc = 0;
    start = 1'b1;
    k_len = 10'(k);
    cyc();
    start = 1'b0;
    k_len = '0;
    check("busy_after_start", busy, (k != 0));
    for (int i = 0; i < k; i++) begin
      if (gaps) begin
        // en_in low: no MAC; stray start in ACCUM must be ignored
        en_in = 1'b0;
        en_psum = 1'b1;
        start = 1'b1;
        k_len = 10'd7;
        weight_in = 16'h5555;
        cyc();
        start = 1'b0;
        en_psum = 1'b0;
        check("gap_busy", busy, 1);
      end
      w = rnd ? 16'($urandom) : w0;
      f = rnd ? 16'($urandom) : f0;
      weight_in = w;
      ifmap_sel_ctrl = sel;
      ifmap_in_bram = sel ? f : 16'($urandom);
      ifmap_in_nbr = sel ? 16'($urandom) : f;
      en_in = 1'b1;
      en_psum = 1'b1;
      acc = sat40(acc + longint'($signed(w)) * longint'($signed(f)));
      cyc();
      en_in = 1'b0;
      en_psum = 1'b0;
      check("fwd_weight", weight_out, w);
      check("fwd_ifmap", ifmap_out, f);
      if (i < k - 1) check("mid_busy", busy, 1);
    end
    check("done_set", done, 1);
    check("busy_clear", busy, 0);
    // A MAC in DONE must not disturb the pending result
    en_in = 1'b1;
    en_psum = 1'b1;
    weight_in = 16'h7fff;
    ifmap_in_nbr = 16'h7fff;
    ifmap_in_bram = 16'h7fff;
    cyc();
    en_in = 1'b0;
    en_psum = 1'b0;
    check("done_hold", done, 1);
    check("fwd_in_done", weight_out, 16'h7fff);
    exp_q.push_back(model_res(acc));
    // Eject wins over start; upstream data is ignored this cycle
    output_eject_ctrl = 1'b1;
    start = 1'b1;
    k_len = 10'd2;
    output_in = 16'hbeef;
    output_in_valid = 1'b1;
    cyc();
    output_eject_ctrl = 1'b0;
    start = 1'b0;
    output_in_valid = 1'b0;
    check("idle_after_eject", {busy, done}, 2'b00);
    cyc();
    check("valid_one_cycle", output_out_valid, 0);
  endtask

  initial begin
    rst = 1'b0;
    cyc();
    cyc();
    check("rst_outs", {weight_out, ifmap_out, output_out}, 0);
    check("rst_flags", {output_out_valid, busy, done}, 0);
    rst = 1'b1;
    cyc();

    run_job(3, 16'h0100, 16'h0200, 1'b0, 1'b1, 1'b0);   // 0x0600
    run_job(1, 16'hff00, 16'h0300, 1'b0, 1'b0, 1'b0);   // 0xFD00
    run_job(4, 16'h7fff, 16'h7fff, 1'b0, 1'b1, 1'b0);   // sat 0x7FFF
    run_job(4, 16'h8000, 16'h7fff, 1'b0, 1'b0, 1'b0);   // sat 0x8000
    run_job(0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);   // k_len=0 -> 0x0000
    run_job(5, 16'h0123, 16'hfe77, 1'b0, 1'b1, 1'b1);   // gaps mid-ACCUM

    // Pass-through in IDLE, then hold with eject low
    output_eject_ctrl = 1'b1;
    output_in = 16'h1234;
    output_in_valid = 1'b1;
    exp_q.push_back(16'h1234);
    cyc();
    output_eject_ctrl = 1'b0;
    output_in = 16'h9999;
    output_in_valid = 1'b1;
    cyc();
    check("chain_hold_data", output_out, 16'h1234);
    check("chain_hold_valid", output_out_valid, 0);
    output_in_valid = 1'b0;

    for (int j = 0; j < 4; j++) begin
      run_job(1 + j * 2, 16'h0, 16'h0, 1'b1, j[0], j[1]);
    end

    // Reset after 2 of 5 MACs
    start = 1'b1;
    k_len = 10'd5;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      en_in = 1'b1;
      en_psum = 1'b1;
      weight_in = 16'h0a0a;
      ifmap_in_bram = 16'h0b0b;
      ifmap_sel_ctrl = 1'b1;
      cyc();
    end
    en_in = 1'b0;
    en_psum = 1'b0;
    check("pre_rst_busy", busy, 1);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    check("midrst_outs", {weight_out, ifmap_out, output_out}, 0);
    check("midrst_flags", {output_out_valid, busy, done}, 0);
    run_job(1, 16'h0100, 16'h0100, 1'b0, 1'b0, 1'b0);   // 0x0100

    cyc();
    cyc();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
